// File: rtl/md_unit.sv
// md_unit: multiply/divide unit holding the HI/LO register pair.
//
// Parameters
//   MULT_CYCLES  busy cycles for mult, multu and msub
//   DIV_CYCLES   busy cycles for div and divu
//
// Ports
//   clk    single clock, all state updates on the rising edge
//   reset  synchronous active-low reset
//   Start  a valid MD instruction sits in the E stage this cycle
//   MDOp   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 msub,
//          8-15 reserved (ignored)
//   A, B   forwarded rs / rt operands
//   Busy   a multi-cycle operation is in progress
//   HI, LO result registers
//
// Operands and the opcode are latched on accept. The result is computed from
// the latched values and written on the edge where Busy falls, so a
// mfhi/mflo released on that edge sees the new value.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MSUB  = 4'd7
   } mdOp_t;

   state_t      state;
   logic [31:0] counter;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [3:0]  opReg;

   logic        accept;
   logic        startIsDiv;

   logic signed [63:0] prodS;
   logic [63:0] prodU;
   logic [63:0] msubRes;
   logic [31:0] magA;
   logic [31:0] magB;
   logic [31:0] divisorS;
   logic [31:0] divisorU;
   logic [31:0] qMag;
   logic [31:0] rMag;
   logic [31:0] divQ;
   logic [31:0] divR;
   logic [31:0] divuQ;
   logic [31:0] divuR;
   logic        writeHiLo;
   logic [31:0] nextHi;
   logic [31:0] nextLo;

   assign Busy       = (state == RUN);
   assign accept     = Start && (state == IDLE) && (MDOp != 4'(OP_NONE)) && (MDOp <= 4'(OP_MSUB));
   assign startIsDiv = (MDOp == 4'(OP_DIV)) || (MDOp == 4'(OP_DIVU));

   // Result datapath, evaluated from the latched operands.
   always_comb begin
      prodS    = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
      prodU    = {32'd0, opA} * {32'd0, opB};
      msubRes  = {HI, LO} - $unsigned(prodS);

      // Signed divide done on magnitudes: this keeps 0x80000000 / -1 well
      // defined (quotient wraps to 0x80000000, remainder 0).
      magA     = opA[31] ? -opA : opA;
      magB     = opB[31] ? -opB : opB;
      // Divisor forced to 1 on zero so the divider never sees 0; the
      // result is discarded in that case anyway.
      divisorS = (opB == '0) ? 32'd1 : magB;
      divisorU = (opB == '0) ? 32'd1 : opB;
      qMag     = magA / divisorS;
      rMag     = magA % divisorS;
      divQ     = (opA[31] ^ opB[31]) ? -qMag : qMag;
      divR     = opA[31] ? -rMag : rMag;
      divuQ    = opA / divisorU;
      divuR    = opA % divisorU;

      writeHiLo = 1'b0;
      nextHi    = HI;
      nextLo    = LO;
      case (opReg)
         4'(OP_MULT):  begin writeHiLo = 1'b1; {nextHi, nextLo} = prodS;   end
         4'(OP_MULTU): begin writeHiLo = 1'b1; {nextHi, nextLo} = prodU;   end
         4'(OP_MSUB):  begin writeHiLo = 1'b1; {nextHi, nextLo} = msubRes; end
         4'(OP_DIV):   begin writeHiLo = (opB != '0); nextHi = divR;  nextLo = divQ;  end
         4'(OP_DIVU):  begin writeHiLo = (opB != '0); nextHi = divuR; nextLo = divuQ; end
         default:      writeHiLo = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         counter <= '0;
         opA     <= '0;
         opB     <= '0;
         opReg   <= '0;
         HI      <= '0;
         LO      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  opA   <= A;
                  opB   <= B;
                  opReg <= MDOp;
                  if (MDOp == 4'(OP_MTHI)) begin
                     HI <= A;
                  end else if (MDOp == 4'(OP_MTLO)) begin
                     LO <= A;
                  end else begin
                     counter <= startIsDiv ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                     state   <= RUN;
                  end
               end
            end
            RUN: begin
               if (counter == 32'd1) begin
                  state   <= IDLE;
                  counter <= '0;
                  if (writeHiLo) begin
                     HI <= nextHi;
                     LO <= nextLo;
                  end
               end else begin
                  counter <= counter - 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized self-checking bench for md_unit against an
// arithmetic reference model of the HI/LO pair and the busy duration.
module tb_md_unit;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk;
   logic        reset;
   logic        Start;
   logic [3:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;

   logic [31:0] expHi = '0;
   logic [31:0] expLo = '0;

   md_unit #(
      .MULT_CYCLES(MC),
      .DIV_CYCLES (DC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .Start(Start),
      .MDOp (MDOp),
      .A    (A),
      .B    (B),
      .Busy (Busy),
      .HI   (HI),
      .LO   (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: updates expHi/expLo and returns the expected busy length.
   task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     hl;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      hl = {expHi, expLo};
      cycles = 0;
      case (op)
         4'd1: begin cycles = MC; hl = sa * sb; end
         4'd2: begin cycles = MC; hl = ua * ub; end
         4'd7: begin cycles = MC; hl = hl - 64'(sa * sb); end
         4'd3: begin
            cycles = DC;
            if (b != 0) begin
               q = sa / sb;
               r = sa % sb;
               hl = {r[31:0], q[31:0]};
            end
         end
         4'd4: begin
            cycles = DC;
            if (b != 0) hl = {32'(ua % ub), 32'(ua / ub)};
         end
         4'd5: hl[63:32] = a;
         4'd6: hl[31:0]  = a;
         default: ;
      endcase
      {expHi, expLo} = hl;
   endtask

   // Issue one Start, scribble ignored Start pulses during Busy, then check
   // the busy length and the resulting HI/LO.
   task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      int expCycles;
      int busyCount;
      int guard;
      modelOp(op, a, b, expCycles);
      @(negedge clk);
      checkVal({tag, "_idle"}, 64'(Busy), 64'd0);
      Start = 1'b1;
      MDOp  = op;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      Start = 1'b0;
      busyCount = 0;
      guard = 0;
      while (Busy && guard < 200) begin
         busyCount++;
         guard++;
         Start = 1'($urandom_range(0, 1));
         MDOp  = 4'($urandom);
         A     = $urandom;
         B     = $urandom;
         @(posedge clk);
         #1;
      end
      Start = 1'b0;
      checkVal({tag, "_busy"}, 64'(busyCount), 64'(expCycles));
      checkVal({tag, "_hi"}, 64'(HI), 64'(expHi));
      checkVal({tag, "_lo"}, 64'(LO), 64'(expLo));
   endtask

   initial begin
      reset = 1'b0;
      Start = 1'b0;
      MDOp  = '0;
      A     = '0;
      B     = '0;
      repeat (2) @(posedge clk);
      #1;
      checkVal("rst_busy", 64'(Busy), 64'd0);
      checkVal("rst_hi", 64'(HI), 64'd0);
      checkVal("rst_lo", 64'(LO), 64'd0);
      reset = 1'b1;

      // Directed cases
      runOp("mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3);
      checkVal("mult_neg_abs", {32'(HI), 32'(LO)}, 64'hFFFFFFFF_FFFFFFFA);
      runOp("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      checkVal("multu_abs", {32'(HI), 32'(LO)}, 64'hFFFFFFFE_00000001);
      runOp("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2);
      checkVal("div_neg_abs", {32'(HI), 32'(LO)}, 64'hFFFFFFFF_FFFFFFFD);
      runOp("mthi11", 4'd5, 32'h11, 32'd0);
      runOp("mtlo22", 4'd6, 32'h22, 32'd0);
      runOp("divu_zero", 4'd4, 32'd9, 32'd0);
      checkVal("divu_zero_abs", {32'(HI), 32'(LO)}, 64'h00000011_00000022);
      runOp("div_zero", 4'd3, 32'h12345678, 32'd0);
      runOp("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
      checkVal("div_ovf_abs", {32'(HI), 32'(LO)}, 64'h00000000_80000000);
      runOp("mthi5", 4'd5, 32'd5, 32'd0);
      runOp("mtlo0", 4'd6, 32'd0, 32'd0);
      runOp("msub", 4'd7, 32'd2, 32'd3);
      checkVal("msub_abs", {32'(HI), 32'(LO)}, 64'h00000004_FFFFFFFA);
      runOp("op_none", 4'd0, 32'hDEADBEEF, 32'd1);
      runOp("op_rsvd", 4'd9, 32'hDEADBEEF, 32'd1);
      runOp("op_rsvd15", 4'd15, 32'hCAFEF00D, 32'd1);

      // Reset in the 4th busy cycle of a div, with a Start pulse alongside
      @(negedge clk);
      Start = 1'b1;
      MDOp  = 4'd3;
      A     = 32'd100;
      B     = 32'd7;
      @(posedge clk);
      #1;
      Start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkVal("rst_mid_busy_before", 64'(Busy), 64'd1);
      reset = 1'b0;
      Start = 1'b1;
      MDOp  = 4'd1;
      @(posedge clk);
      #1;
      checkVal("rst_mid_busy", 64'(Busy), 64'd0);
      checkVal("rst_mid_hi", 64'(HI), 64'd0);
      checkVal("rst_mid_lo", 64'(LO), 64'd0);
      reset = 1'b1;
      Start = 1'b0;
      expHi = '0;
      expLo = '0;
      @(posedge clk);
      #1;
      checkVal("rst_after_busy", 64'(Busy), 64'd0);

      // Randomized mix
      for (int i = 0; i < 80; i++) begin
         logic [3:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         if (i % 9 == 8) op = (($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(8, 15)));
         else            op = 4'($urandom_range(1, 7));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'($signed(32'($urandom_range(0, 40))) - 20);
         if ($urandom_range(0, 3) == 0) b = 32'($signed(32'($urandom_range(0, 40))) - 20);
         if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 7) == 0) b = '0;
         runOp("rand", op, a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu/msub.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; 0 at a rising edge resets the block.
REQ-005 Start  in  1  a valid MD instruction is in E stage this cycle.
REQ-006 MDOp  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 msub; 8-15 reserved.
REQ-007 A  in  32  rs operand, forwarded value.
REQ-008 B  in  32  rt operand, forwarded value.
REQ-009 Busy  out  1  multi-cycle operation in progress; drives the hazard unit busy input.
REQ-010 HI  out  32  HI register, registered output.
REQ-011 LO  out  32  LO register, registered output.

Function
REQ-012 A start is accepted only when Start=1, Busy=0, reset=1 and MDOp is 1-7; otherwise no state changes.
REQ-013 While Busy=1, Start is ignored; operands and op held internally stay unchanged.
REQ-014 Busy stays 0 in the start cycle; the hazard unit covers that cycle via its E-stage MD signal.
REQ-015 FSM states: IDLE and RUN; IDLE->RUN on an accepted op 1-4 or 7; RUN->IDLE when the down-counter reaches 1.
REQ-016 Busy=1 exactly while state=RUN.
REQ-017 On accept, A, B and op are latched; the counter loads MULT_CYCLES (ops 1,2,7) or DIV_CYCLES (ops 3,4).
REQ-018 Busy is high for exactly MULT_CYCLES or DIV_CYCLES consecutive cycles.
REQ-019 HI/LO update on the same edge on which Busy falls; a mfhi/mflo released on that edge reads the new value.
REQ-020 mult: {HI,LO} = signed 64-bit product of the latched A and B.
REQ-021 multu: {HI,LO} = unsigned 64-bit product.
REQ-022 msub: {HI,LO} = {HI,LO} - signed(A*B); 64-bit two's complement, wrap-around, no overflow flag.
REQ-023 div: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign.
REQ-024 div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-025 divu: LO = unsigned quotient, HI = unsigned remainder.
REQ-026 div or divu with B=0: full DIV_CYCLES busy time; HI and LO unchanged.
REQ-027 mthi (5): HI=A on the accept edge; LO unchanged; Busy stays 0.
REQ-028 mtlo (6): LO=A on the accept edge; HI unchanged; Busy stays 0.
REQ-029 Ops 5 and 6 do not enter RUN.
REQ-030 Start=1 with MDOp=0 or 8-15: no effect.
REQ-031 Start=1 on the completion edge (Busy=1) is ignored; the next accept occurs no earlier than the following cycle.

Reset
REQ-032 reset=0 at a rising edge: HI=0, LO=0, Busy=0, state=IDLE, counter=0, latched operands=0.
REQ-033 Reset wins over every other event, including mid-operation; an in-flight result is discarded.
REQ-034 Outputs reach reset values one edge after reset=0 is sampled; there is no asynchronous path.

Verification
REQ-035 mult A=0xFFFFFFFE(-2), B=3 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 div A=-7, B=2 -> Busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 divu A=9, B=0 with HI=0x11, LO=0x22 -> Busy high for 10 cycles; HI=0x11, LO=0x22 unchanged.
REQ-039 mthi A=5, then msub A=2, B=3 with LO=0 -> HI=0x00000004, LO=0xFFFFFFFA after 5 busy cycles.
REQ-040 Start div, assert reset=0 on 4th busy cycle -> next edge Busy=0, HI=LO=0; a Start pulse during Busy is ignored.
